// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I-subset control FSM.
package mc_ctrl_pkg;

    // One state per clock of an instruction's lifetime.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_ALU_WB   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_LD_WB    = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JAL      = 4'd10
    } state_t;

    // What the ALU is being used for in the current state.
    typedef enum logic [1:0] {
        ALU_CLS_ADD = 2'd0,
        ALU_CLS_SUB = 2'd1,
        ALU_CLS_R   = 2'd2,
        ALU_CLS_I   = 2'd3
    } alu_cls_t;

    localparam logic [3:0] ALUCTL_AND = 4'b0000;
    localparam logic [3:0] ALUCTL_OR  = 4'b0001;
    localparam logic [3:0] ALUCTL_ADD = 4'b0010;
    localparam logic [3:0] ALUCTL_SUB = 4'b0110;
    localparam logic [3:0] ALUCTL_SLT = 4'b0100;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BLT = 3'b100;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_RS1   = 2'd1;
    localparam logic [1:0] SRC_A_OLDPC = 2'd2;

    localparam logic [1:0] SRC_B_RS2   = 2'd0;
    localparam logic [1:0] SRC_B_FOUR  = 2'd1;
    localparam logic [1:0] SRC_B_IMM   = 2'd2;

    localparam logic [1:0] M2R_ALUOUT  = 2'd0;
    localparam logic [1:0] M2R_MDR     = 2'd1;
    localparam logic [1:0] M2R_PC      = 2'd2;

    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_ALUOUT = 1'b1;

    // funct3 values the ALU-op (R/I) instructions support.
    function automatic logic alu_f3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_ADD, F3_AND, F3_OR, F3_SLT: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_ctl_dec.sv
// Combinational ALUctl decode from the ALU usage class and the instruction funct fields.
module alu_ctl_dec
    import mc_ctrl_pkg::*;
(
    input  alu_cls_t   cls,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_ctl
);

    // Select the ALU operation; address/PC arithmetic is always ADD.
    always_comb begin
        alu_ctl = ALUCTL_ADD;
        case (cls)
            ALU_CLS_ADD: alu_ctl = ALUCTL_ADD;
            ALU_CLS_SUB: alu_ctl = ALUCTL_SUB;
            ALU_CLS_R, ALU_CLS_I: begin
                case (funct3)
                    F3_ADD: begin
                        // Only register-register ops use bit 30 as SUB; for immediates it is imm data.
                        if ((cls == ALU_CLS_R) && funct7_5) begin
                            alu_ctl = ALUCTL_SUB;
                        end else begin
                            alu_ctl = ALUCTL_ADD;
                        end
                    end
                    F3_AND:  alu_ctl = ALUCTL_AND;
                    F3_OR:   alu_ctl = ALUCTL_OR;
                    F3_SLT:  alu_ctl = ALUCTL_SLT;
                    default: alu_ctl = ALUCTL_ADD;
                endcase
            end
            default: alu_ctl = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I-subset datapath.
// Optional feature macro: MC_CTRL_BLT_EN (makes branch funct3=100, BLT, legal).
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTL_W  = 4,
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 zero,
    input  logic                 blt,
    output logic [ALUCTL_W-1:0]  ALUctl,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 ir_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic [1:0]           mem_to_reg,
    output logic                 illegal_op,
    output logic [INSTRET_W-1:0] instret
);

    state_t                 state_r;
    state_t                 next_state_s;
    alu_cls_t               alu_cls_s;
    logic [3:0]             alu_ctl_s;
    logic [1:0]             src_a_s;
    logic [1:0]             src_b_s;
    logic                   pc_write_s;
    logic                   pc_src_s;
    logic                   ir_write_s;
    logic                   mem_read_s;
    logic                   mem_write_s;
    logic                   reg_write_s;
    logic [1:0]             mem_to_reg_s;
    logic                   illegal_s;
    logic                   retire_s;
    logic                   br_f3_ok_s;
    logic [INSTRET_W-1:0]   instret_r;

`ifdef MC_CTRL_BLT_EN
    assign br_f3_ok_s = (funct3 == F3_BEQ) || (funct3 == F3_BLT);
`else
    assign br_f3_ok_s = (funct3 == F3_BEQ);
`endif

    alu_ctl_dec u_alu_ctl_dec (
        .cls      (alu_cls_s),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_ctl  (alu_ctl_s)
    );

    // State register; reset returns to FETCH and abandons any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and Moore output decode; only BRANCH's pc_write looks at the ALU flags.
    always_comb begin
        next_state_s = state_r;
        alu_cls_s    = ALU_CLS_ADD;
        src_a_s      = SRC_A_PC;
        src_b_s      = SRC_B_RS2;
        pc_write_s   = 1'b0;
        pc_src_s     = PC_SRC_ALU;
        ir_write_s   = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        mem_to_reg_s = M2R_ALUOUT;
        illegal_s    = 1'b0;
        retire_s     = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_read_s   = 1'b1;
                ir_write_s   = 1'b1;
                src_a_s      = SRC_A_PC;
                src_b_s      = SRC_B_FOUR;
                pc_write_s   = 1'b1;
                pc_src_s     = PC_SRC_ALU;
                next_state_s = ST_DECODE;
            end
            ST_DECODE: begin
                // Branch target precomputed into ALUOut regardless of opcode.
                src_a_s = SRC_A_OLDPC;
                src_b_s = SRC_B_IMM;
                case (opcode)
                    OP_R: begin
                        if (alu_f3_legal(funct3)) begin
                            next_state_s = ST_EXEC_R;
                        end else begin
                            illegal_s    = 1'b1;
                            next_state_s = ST_FETCH;
                        end
                    end
                    OP_I: begin
                        if (alu_f3_legal(funct3)) begin
                            next_state_s = ST_EXEC_I;
                        end else begin
                            illegal_s    = 1'b1;
                            next_state_s = ST_FETCH;
                        end
                    end
                    OP_LOAD, OP_STORE: next_state_s = ST_MEM_ADDR;
                    OP_BRANCH: begin
                        if (br_f3_ok_s) begin
                            next_state_s = ST_BRANCH;
                        end else begin
                            illegal_s    = 1'b1;
                            next_state_s = ST_FETCH;
                        end
                    end
                    OP_JAL: next_state_s = ST_JAL;
                    default: begin
                        illegal_s    = 1'b1;
                        next_state_s = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC_R: begin
                alu_cls_s    = ALU_CLS_R;
                src_a_s      = SRC_A_RS1;
                src_b_s      = SRC_B_RS2;
                next_state_s = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                alu_cls_s    = ALU_CLS_I;
                src_a_s      = SRC_A_RS1;
                src_b_s      = SRC_B_IMM;
                next_state_s = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = M2R_ALUOUT;
                retire_s     = 1'b1;
                next_state_s = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                src_a_s = SRC_A_RS1;
                src_b_s = SRC_B_IMM;
                if (opcode == OP_LOAD) begin
                    next_state_s = ST_MEM_RD;
                end else begin
                    next_state_s = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                mem_read_s   = 1'b1;
                next_state_s = ST_LD_WB;
            end
            ST_LD_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = M2R_MDR;
                retire_s     = 1'b1;
                next_state_s = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write_s  = 1'b1;
                retire_s     = 1'b1;
                next_state_s = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_cls_s    = ALU_CLS_SUB;
                src_a_s      = SRC_A_RS1;
                src_b_s      = SRC_B_RS2;
                pc_src_s     = PC_SRC_ALUOUT;
                pc_write_s   = ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BLT) && blt);
                retire_s     = 1'b1;
                next_state_s = ST_FETCH;
            end
            ST_JAL: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = M2R_PC;
                pc_src_s     = PC_SRC_ALUOUT;
                pc_write_s   = 1'b1;
                retire_s     = 1'b1;
                next_state_s = ST_FETCH;
            end
            default: next_state_s = ST_FETCH;
        endcase
    end

    // Retired-instruction counter; wraps naturally at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_r <= {INSTRET_W{1'b0}};
        end else if (retire_s) begin
            instret_r <= instret_r + INSTRET_W'(1'b1);
        end else begin
            instret_r <= instret_r;
        end
    end

    // Reset dominates the decode so FETCH's enables cannot fire while rst_n is low.
    assign ALUctl     = rst_n ? ALUCTL_W'(alu_ctl_s) : ALUCTL_W'(ALUCTL_ADD);
    assign alu_src_a  = rst_n ? src_a_s : 2'b00;
    assign alu_src_b  = rst_n ? src_b_s : 2'b00;
    assign pc_write   = rst_n & pc_write_s;
    assign pc_src     = rst_n & pc_src_s;
    assign ir_write   = rst_n & ir_write_s;
    assign mem_read   = rst_n & mem_read_s;
    assign mem_write  = rst_n & mem_write_s;
    assign reg_write  = rst_n & reg_write_s;
    assign mem_to_reg = rst_n ? mem_to_reg_s : 2'b00;
    assign illegal_op = rst_n & illegal_s;
    assign instret    = instret_r;

endmodule
